// File: rtl/lmsm_sequencer_pkg.sv
// rtl/lmsm_sequencer_pkg.sv - shared widths, state encoding and index-width helper for the LM/SM sequencer
package lmsm_sequencer_pkg;

  localparam int LMSM_DATA_W = 16;
  localparam int LMSM_ADDR_W = 16;
  localparam int LMSM_NREG   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } lmsm_state_e;

  // Register index width, kept at least 1 so a single-register file still has a port.
  function automatic int reg_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// rtl/lmsm_sequencer_if.sv - command, register-file and memory signals of the LM/SM sequencer
interface lmsm_sequencer_if
  import lmsm_sequencer_pkg::*;
#(
  parameter int DATA_W = LMSM_DATA_W,
  parameter int ADDR_W = LMSM_ADDR_W,
  parameter int NREG   = LMSM_NREG
) ();

  localparam int RA_W = reg_idx_w(NREG);

  logic              start;
  logic              is_load;
  logic [NREG-1:0]   reg_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;

  logic [RA_W-1:0]   rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic [RA_W-1:0]   rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;
  logic              rf_wr_en;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              mem_ready;

  modport master (
    output start, is_load, reg_mask, base_addr, rf_rd_data, mem_rd_data, mem_ready,
    input  busy, done, rf_rd_addr, rf_wr_addr, rf_wr_data, rf_wr_en,
           mem_addr, mem_wr_data, mem_rd_en, mem_wr_en
  );

  modport slave (
    input  start, is_load, reg_mask, base_addr, rf_rd_data, mem_rd_data, mem_ready,
    output busy, done, rf_rd_addr, rf_wr_addr, rf_wr_data, rf_wr_en,
           mem_addr, mem_wr_data, mem_rd_en, mem_wr_en
  );

endinterface

// File: rtl/lmsm_sequencer_lowest_set_bit.sv
// rtl/lmsm_sequencer_lowest_set_bit.sv - priority encoder returning the lowest set bit index of a mask
module lowest_set_bit #(
  parameter int W     = 8,
  parameter int IDX_W = 3
) (
  input  logic [W-1:0]     mask_i,
  output logic [IDX_W-1:0] index_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    index_o = '0;
    valid_o = |mask_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// rtl/lmsm_sequencer.sv - load/store-multiple sequencer walking a register mask against consecutive memory words
module lmsm_sequencer
  import lmsm_sequencer_pkg::*;
#(
  parameter int DATA_W = LMSM_DATA_W,
  parameter int ADDR_W = LMSM_ADDR_W,
  parameter int NREG   = LMSM_NREG
) (
  input logic             clk,
  input logic             rst_n,
  lmsm_sequencer_if.slave bus
);

  localparam int RA_W = reg_idx_w(NREG);

  lmsm_state_e       state_q, state_d;
  logic [NREG-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load_q, load_d;

  logic [RA_W-1:0]   cur_idx;
  logic              cur_valid;
  logic              xfer_active;

  lowest_set_bit #(
    .W     (NREG),
    .IDX_W (RA_W)
  ) u_lowest_set_bit (
    .mask_i  (mask_q),
    .index_o (cur_idx),
    .valid_o (cur_valid)
  );

  assign xfer_active = (state_q == ST_XFER) && cur_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d  = bus.reg_mask;
          addr_d  = bus.base_addr;
          load_d  = bus.is_load;
          state_d = (|bus.reg_mask) ? ST_XFER : ST_DONE;
        end
      end
      ST_XFER: begin
        // A stalled access (mem_ready low) leaves mask and address untouched.
        if (bus.mem_ready && cur_valid) begin
          mask_d = mask_q & ~(NREG'(1) << cur_idx);
          addr_d = addr_q + ADDR_W'(1);
          if (~|mask_d) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything outside an active transfer is driven to zero, so reset clears outputs at once.
  always_comb begin
    bus.busy        = (state_q != ST_IDLE);
    bus.done        = (state_q == ST_DONE);
    bus.rf_rd_addr  = '0;
    bus.rf_wr_addr  = '0;
    bus.rf_wr_data  = DATA_W'(0);
    bus.rf_wr_en    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = DATA_W'(0);
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    if (xfer_active) begin
      bus.mem_addr = addr_q;
      if (load_q) begin
        bus.mem_rd_en  = 1'b1;
        bus.rf_wr_addr = cur_idx;
        if (bus.mem_ready) begin
          bus.rf_wr_en   = 1'b1;
          bus.rf_wr_data = bus.mem_rd_data;
        end
      end else begin
        bus.rf_rd_addr  = cur_idx;
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = bus.rf_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb/tb_lmsm_sequencer.sv - self-checking bench for lmsm_sequencer against a transfer-list reference model
module tb_lmsm_sequencer;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lmsm_sequencer_if #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) bus ();

  lmsm_sequencer #(.DATA_W(DW), .ADDR_W(AW), .NREG(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [65536];
  logic [DW-1:0] regs [NR];

  assign bus.rf_rd_data  = regs[bus.rf_rd_addr];
  assign bus.mem_rd_data = mem[bus.mem_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xfer_t;

  typedef struct {
    logic          is_load;
    logic [NR-1:0] mask;
    logic [AW-1:0] base;
    int            stall;
    int            poke;
    int            exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.rf_wr_en}), 32'd0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    check({tag, "_mem_wr_data"}, 32'(bus.mem_wr_data), 32'd0);
    check({tag, "_rf_wr_data"}, 32'(bus.rf_wr_data), 32'd0);
    check({tag, "_rf_addrs"}, 32'({bus.rf_rd_addr, bus.rf_wr_addr}), 32'd0);
  endtask

  // Model: the operation is an ordered list of (register, address, data) transfers, one
  // per set mask bit from low to high at consecutive wrapping addresses; each ready cycle
  // retires the head, and the cycle after the list empties must carry done.
  task automatic run_op(input logic ld, input logic [NR-1:0] mask, input logic [AW-1:0] base,
                        input int stall, input int poke, output int done_cycle);
    xfer_t         q[$];
    xfer_t         e;
    logic [AW-1:0] a;
    logic          rdy;
    a = base;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        e.idx  = i;
        e.addr = a;
        e.data = ld ? mem[a] : regs[i];
        q.push_back(e);
        a = a + AW'(1);
      end
    end
    done_cycle    = -1;
    bus.start     = 1'b1;
    bus.is_load   = ld;
    bus.reg_mask  = mask;
    bus.base_addr = base;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.is_load   = 1'($urandom_range(0, 1));
    bus.reg_mask  = NR'($urandom);
    bus.base_addr = AW'($urandom);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (stall < 0) rdy = ($urandom_range(0, 3) != 0);
      else           rdy = (cyc > stall);
      bus.mem_ready = rdy;
      bus.start     = (cyc == poke);
      if (cyc == poke) begin
        bus.is_load   = ~ld;
        bus.reg_mask  = ~mask;
        bus.base_addr = base ^ 16'h5A5A;
      end
      #1;
      if (q.size() > 0) begin
        e = q[0];
        check("busy", 32'(bus.busy), 32'd1);
        check("done_early", 32'(bus.done), 32'd0);
        check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
        check("strobes", 32'({bus.mem_rd_en, bus.mem_wr_en, bus.rf_wr_en}), 32'({ld, ~ld, ld & rdy}));
        if (ld && rdy) begin
          check("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(e.idx));
          check("rf_wr_data", 32'(bus.rf_wr_data), 32'(e.data));
          regs[bus.rf_wr_addr] = bus.rf_wr_data;
        end
        if (!ld) begin
          check("rf_rd_addr", 32'(bus.rf_rd_addr), 32'(e.idx));
          check("mem_wr_data", 32'(bus.mem_wr_data), 32'(e.data));
          if (rdy) mem[bus.mem_addr] = bus.mem_wr_data;
        end
        if (rdy) void'(q.pop_front());
      end else begin
        check("done", 32'(bus.done), 32'd1);
        check("busy_at_done", 32'(bus.busy), 32'd1);
        check("strobes_at_done", 32'({bus.mem_rd_en, bus.mem_wr_en, bus.rf_wr_en}), 32'd0);
        done_cycle = cyc;
        break;
      end
      @(negedge clk);
    end
    if (done_cycle < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 200 cycles, required done after %0d transfers left", q.size());
    end
    @(negedge clk);
    bus.start     = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("busy_after", 32'(bus.busy), 32'd0);
    check("done_after", 32'(bus.done), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int   dc;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_load   = 1'b0;
    bus.reg_mask  = '0;
    bus.base_addr = '0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
    mem[16'h0010] = 16'hAAAA;
    mem[16'h0011] = 16'hBBBB;

    vecs[0] = '{1'b1, 8'h05, 16'h0010, 0, 0, 3};
    vecs[1] = '{1'b0, 8'h81, 16'h0100, 0, 0, 3};
    vecs[2] = '{1'b1, 8'h00, 16'h0040, 0, 0, 1};
    vecs[3] = '{1'b1, 8'hFF, 16'hFFFE, 0, 0, 9};
    vecs[4] = '{1'b0, 8'h06, 16'h0200, 3, 2, 6};

    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_zero("post_reset");

    for (int v = 0; v < 5; v++) begin
      if (v == 1) begin
        regs[0] = 16'h1234;
        regs[7] = 16'h5678;
      end
      run_op(vecs[v].is_load, vecs[v].mask, vecs[v].base, vecs[v].stall, vecs[v].poke, dc);
      check($sformatf("done_cycle_v%0d", v), 32'(dc), 32'(vecs[v].exp_done));
      if (v == 0) begin
        check("v0_r0", 32'(regs[0]), 32'h0000_AAAA);
        check("v0_r2", 32'(regs[2]), 32'h0000_BBBB);
      end
      if (v == 1) begin
        check("v1_mem100", 32'(mem[16'h0100]), 32'h0000_1234);
        check("v1_mem101", 32'(mem[16'h0101]), 32'h0000_5678);
      end
    end

    // Reset in the middle of the second load of a three-register transfer.
    mem[16'h0300] = 16'h1111;
    mem[16'h0301] = 16'h2222;
    mem[16'h0302] = 16'h3333;
    regs[1] = 16'hDEAD;
    regs[2] = 16'hDEAD;
    bus.start     = 1'b1;
    bus.is_load   = 1'b1;
    bus.reg_mask  = 8'h07;
    bus.base_addr = 16'h0300;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("rst_seq_c1_wr", 32'({bus.rf_wr_en, bus.rf_wr_addr}), 32'({1'b1, 3'd0}));
    check("rst_seq_c1_data", 32'(bus.rf_wr_data), 32'h0000_1111);
    regs[bus.rf_wr_addr] = bus.rf_wr_data;
    @(negedge clk);
    #1;
    check("rst_seq_c2_addr", 32'(bus.mem_addr), 32'h0000_0301);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    #1;
    check_zero("rst_hold");
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_zero("rst_after");
    end
    check("rst_r0", 32'(regs[0]), 32'h0000_1111);
    check("rst_r1", 32'(regs[1]), 32'h0000_DEAD);
    check("rst_r2", 32'(regs[2]), 32'h0000_DEAD);
    run_op(vecs[0].is_load, vecs[0].mask, vecs[0].base, 0, 0, dc);
    check("rst_next_done_cycle", 32'(dc), 32'd3);
    check("rst_next_r2", 32'(regs[2]), 32'h0000_BBBB);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NR; i++) regs[i] = DW'($urandom);
      run_op(1'($urandom_range(0, 1)), NR'($urandom), AW'($urandom), -1,
             ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: register and memory data width.
REQ-002 The block SHALL have parameter ADDR_W, default 16: memory address width.
REQ-003 The block SHALL have parameter NREG, default 8: register count and mask width; register address width is log2(NREG) = 3.
REQ-004 Port clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port start  in  1  single-cycle request to begin a multiple transfer.
REQ-007 Port is_load  in  1  1 = load-multiple (memory to registers), 0 = store-multiple (registers to memory).
REQ-008 Port reg_mask  in  NREG  bit i set selects register Ri.
REQ-009 Port base_addr  in  ADDR_W  first memory word address.
REQ-010 Port rf_rd_data  in  DATA_W  combinational register-file read data for rf_rd_addr.
REQ-011 Port mem_rd_data  in  DATA_W  memory read data, valid when mem_ready=1.
REQ-012 Port mem_ready  in  1  memory accepts/completes the current access this cycle.
REQ-013 Port busy  out  1  high from the cycle after an accepted start until done inclusive.
REQ-014 Port done  out  1  single-cycle completion pulse.
REQ-015 Port rf_rd_addr  out  3  register read address (store path).
REQ-016 Port rf_wr_addr, rf_wr_data, rf_wr_en  out  3/DATA_W/1  register write port (load path).
REQ-017 Port mem_addr, mem_wr_data  out  ADDR_W/DATA_W  memory address and write data.
REQ-018 Port mem_rd_en, mem_wr_en  out  1/1  memory read/write request strobes.

Function
REQ-019 The FSM SHALL have states IDLE, XFER, DONE.
REQ-020 In IDLE, start=1 SHALL latch reg_mask, base_addr and is_load; next state XFER if mask nonzero, else DONE.
REQ-021 start SHALL be ignored while not in IDLE; latched operands SHALL not change mid-operation.
REQ-022 In XFER, the current register SHALL be the lowest-indexed set bit i of the remaining mask; mem_addr SHALL equal the current address.
REQ-023 Load in XFER: mem_rd_en=1; when mem_ready=1, rf_wr_en=1, rf_wr_addr=i, rf_wr_data=mem_rd_data in that same cycle.
REQ-024 Store in XFER: rf_rd_addr=i, mem_wr_en=1, mem_wr_data=rf_rd_data (combinational pass-through).
REQ-025 On a cycle with mem_ready=1 in XFER, bit i SHALL be cleared and address incremented by 1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
REQ-026 With mem_ready=0 the request SHALL be held unchanged, no register write, no mask or address change.
REQ-027 When the last set bit completes, next state SHALL be DONE; DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-028 Latency with mem_ready tied high and N set bits: start sampled at edge 0, transfers in cycles 1..N, done in cycle N+1; N=0 gives done in cycle 1.
REQ-029 rf_wr_en, mem_rd_en, mem_wr_en SHALL be 0 outside XFER; rf_wr_en SHALL be 0 during store.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, clear mask/address/is_load, and drive busy, done, rf_wr_en, mem_rd_en, mem_wr_en to 0 and all address/data outputs to 0.
REQ-031 Reset mid-XFER SHALL abort with no further writes and no done pulse.

Structure
REQ-032 FSM state encoding and the NREG/DATA_W/ADDR_W defaults SHALL live in the shared CPU package.
REQ-033 A priority encoder sub-module, lowest_set_bit (mask in, index and valid out), SHALL select the current register.

Verification
REQ-034 Load, mask 0x05, base 0x0010, mem_ready=1, memory [0x10]=0xAAAA, [0x11]=0xBBBB -> R0=0xAAAA cycle 1, R2=0xBBBB cycle 2, done cycle 3.
REQ-035 Store, mask 0x81, base 0x0100, R0=0x1234, R7=0x5678 -> writes 0x1234@0x0100, 0x5678@0x0101, done cycle 3.
REQ-036 Mask 0x00 -> no strobes, done in cycle 1, busy high only in cycle 1.
REQ-037 Load, mask 0xFF, base 0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000..0x0005; done cycle 9.
REQ-038 Store, mask 0x06, mem_ready low 3 cycles on first access -> request held stable, done cycle 6; start pulsed during busy is ignored.
REQ-039 rst_n low during second transfer of mask 0x07 -> outputs zero immediately, no done, next start behaves normally.
